// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module   : program_loader
// Purpose  : Loads instructions from a byte stream into program memory words
//            0..N-1. The core is held in reset while a load is in progress.
//            Optional macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Revision : 1.0
// ============================================================================
module program_loader #(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 5,
  parameter int BYTE_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_WIDTH:0]    num_instr,
  input  logic                   byte_valid,
  input  logic [BYTE_WIDTH-1:0]  byte_data,
  output logic                   byte_ready,
  output logic                   pm_we,
  output logic [ADDR_WIDTH-1:0]  pm_addr,
  output logic [INSTR_WIDTH-1:0] pm_wdata,
  output logic                   cpu_rst,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOW   = 3'd1,
    S_HIGH  = 3'd2,
    S_WRITE = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd4,
`endif
    S_FIN   = 3'd5
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_last;
  logic                  w_xfer;
  logic                  w_legal;
`ifdef LOADER_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0] r_csum;
`endif

  assign w_xfer  = byte_valid & byte_ready;
  // Legal counts are 1..2**ADDR_WIDTH: nonzero, and the top bit only alone.
  assign w_legal = (num_instr != '0) &&
                   (!num_instr[ADDR_WIDTH] || (num_instr[ADDR_WIDTH-1:0] == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last     <= '0;
      byte_ready <= 1'b0;
      pm_we      <= 1'b0;
      pm_addr    <= '0;
      pm_wdata   <= '0;
      cpu_rst    <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      pm_we <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_legal) begin
              r_last     <= num_instr[ADDR_WIDTH-1:0] - 1'b1;
              pm_addr    <= '0;
              cpu_rst    <= 1'b1;
              busy       <= 1'b1;
              byte_ready <= 1'b1;
              r_state    <= S_LOW;
`ifdef LOADER_CHECKSUM_EN
              r_csum     <= '0;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_LOW: begin
          if (w_xfer) begin
            pm_wdata[BYTE_WIDTH-1:0] <= byte_data;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ byte_data;
`endif
            r_state <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (w_xfer) begin
            pm_wdata[INSTR_WIDTH-1:BYTE_WIDTH] <= byte_data;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ byte_data;
`endif
            byte_ready <= 1'b0;
            pm_we      <= 1'b1;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (pm_addr == r_last) begin
`ifdef LOADER_CHECKSUM_EN
            byte_ready <= 1'b1;
            r_state    <= S_CSUM;
`else
            done    <= 1'b1;
            cpu_rst <= 1'b0;
            r_state <= S_FIN;
`endif
          end else begin
            pm_addr    <= pm_addr + 1'b1;
            byte_ready <= 1'b1;
            r_state    <= S_LOW;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_xfer) begin
            byte_ready <= 1'b0;
            if (byte_data == r_csum) begin
              done    <= 1'b1;
              cpu_rst <= 1'b0;
              r_state <= S_FIN;
            end else begin
              // Failed image: core stays in reset, loader returns to idle.
              err     <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
`endif
        S_FIN: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          byte_ready <= 1'b0;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_program_loader
// Purpose  : Randomized self-checking bench for program_loader; expected memory
//            writes are derived from the generated byte list.
// Revision : 1.0
// ============================================================================
module tb_program_loader;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_instr;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_ready;
  logic          pm_we;
  logic [AW-1:0] pm_addr;
  logic [15:0]   pm_wdata;
  logic          cpu_rst;
  logic          busy;
  logic          done;
  logic          err;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [20:0] obs_q[$];
  logic [7:0]  bytes_q[$];
  bit          noise = 1'b0;

  always #5 clk = ~clk;

  program_loader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_instr  (num_instr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .pm_we      (pm_we),
    .pm_addr    (pm_addr),
    .pm_wdata   (pm_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always @(negedge clk) begin
    if (pm_we) obs_q.push_back({pm_addr, pm_wdata});
    if (done) done_cnt++;
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    check("rst_byte_ready", byte_ready, 0);
    check("rst_pm_we", pm_we, 0);
    check("rst_pm_addr", pm_addr, 0);
    check("rst_pm_wdata", pm_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cpu_rst", cpu_rst, 1);
  endtask

  function automatic logic [7:0] xor_all();
    logic [7:0] x = 8'h00;
    foreach (bytes_q[i]) x ^= bytes_q[i];
    return x;
  endfunction

  task automatic fill(input int n);
    bytes_q.delete();
    for (int i = 0; i < 2 * n; i++) bytes_q.push_back(8'($urandom));
  endtask

  // Offer one byte with random stalls until it is accepted (bounded).
  task automatic push_byte(input logic [7:0] b, input int stall_pct);
    bit got = 1'b0;
    bit quit = 1'b0;
    int n = 0;
    while (!got && !quit) begin
      if ($urandom_range(99) < stall_pct) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
      end else begin
        byte_valid = 1'b1;
        byte_data  = b;
      end
      if (noise) begin
        start     = 1'($urandom_range(1));
        num_instr = 6'($urandom);
      end
      @(negedge clk);
      got = byte_valid && byte_ready;
      tick();
      n++;
      if (!got && n > 300) begin
        check("byte_timeout", 0, 1);
        quit = 1'b1;
      end
    end
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic run_load(input int n, input int stall, input logic [7:0] csum_byte,
                          input bit expect_ok);
    bit seen = 1'b0;
    obs_q.delete();
    done_cnt = 0;
    err_cnt  = 0;
    start     = 1'b1;
    num_instr = 6'(n);
    tick();
    start = 1'b0;
    check("busy_start", busy, 1);
    check("cpu_rst_load", cpu_rst, 1);
    for (int i = 0; i < n; i++) begin
      push_byte(bytes_q[2*i], stall);
      push_byte(bytes_q[2*i+1], stall);
      check("we_latency", pm_we, 1);
      check("wr_addr", pm_addr, 32'(i));
      check("wr_data", pm_wdata, {bytes_q[2*i+1], bytes_q[2*i]});
    end
`ifdef LOADER_CHECKSUM_EN
    push_byte(csum_byte, stall);
`endif
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (done || err) seen = 1'b1;
    end
    check("end_seen", seen, 1);
    check("done_pulse", done, expect_ok);
    check("err_pulse", err, !expect_ok);
    check("cpu_rst_end", cpu_rst, !expect_ok);
    tick();
    check("busy_idle", busy, 0);
    check("done_1cyc", done, 0);
    check("n_writes", obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++)
      check("mem_write", obs_q[i], {i[4:0], bytes_q[2*i+1], bytes_q[2*i]});
    check("done_cnt", done_cnt, expect_ok);
    check("err_cnt", err_cnt, !expect_ok);
  endtask

  initial begin
    int n;
    int bad_n[2];
    rst        = 1'b1;
    start      = 1'b0;
    num_instr  = '0;
    byte_valid = 1'b0;
    byte_data  = '0;
    repeat (3) tick();
    check_reset();
    rst = 1'b0;
    tick();

    // Directed three-word image.
    bytes_q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    run_load(3, 0, xor_all(), 1'b1);

    // Illegal counts: error pulse only, cpu_rst left released.
    obs_q.delete();
    bad_n[0] = 0;
    bad_n[1] = 33;
    foreach (bad_n[j]) begin
      start     = 1'b1;
      num_instr = 6'(bad_n[j]);
      tick();
      start = 1'b0;
      check("err_bad_n", err, 1);
      check("busy_bad_n", busy, 0);
      tick();
      check("err_1cyc", err, 0);
      check("cpu_rst_kept", cpu_rst, 0);
    end
    check("no_we_bad_n", obs_q.size(), 0);

    // Full depth with heavy stalling.
    fill(32);
    run_load(32, 50, xor_all(), 1'b1);

    // Reset mid-load after word 1 written, then reload from address 0.
    fill(4);
    start     = 1'b1;
    num_instr = 6'd4;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(bytes_q[i], 0);
    check("t4_we", pm_we, 1);
    check("t4_addr", pm_addr, 1);
    rst = 1'b1;
    tick();
    check_reset();
    rst = 1'b0;
    fill(3);
    run_load(3, 20, xor_all(), 1'b1);

    // Start pulses while loading must be ignored.
    noise = 1'b1;
    fill(6);
    run_load(6, 30, xor_all(), 1'b1);
    noise = 1'b0;

    repeat (4) begin
      n = $urandom_range(32, 1);
      fill(n);
      run_load(n, $urandom_range(60, 0), xor_all(), 1'b1);
    end

`ifdef LOADER_CHECKSUM_EN
    bytes_q = '{8'h01, 8'h02};
    run_load(1, 0, 8'h03, 1'b1);
    run_load(1, 0, 8'h00, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
